// File: rtl/instr_decode_ctrl.sv
// instr_decode_ctrl: instruction decode and sequencing controller for the RegFile_Alu datapath.
// Accepts 16-bit instruction words over valid/ready, decodes them into register addresses,
// ALU opcode and immediate, sequences IDLE -> EXEC -> WB, captures ALU flags and counts
// retired legal instructions.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_i            asynchronous active-high reset
//   instr_i          instruction word, sampled on handshake
//   instr_valid_i    instr_i is valid
//   instr_ready_o    controller can accept a word
//   flags_i          ALU flag vector from the datapath
//   rdest_reg_loc_o  destination register address
//   rsrc_reg_loc_o   source register address
//   op_code_o        ALU operation
//   imm_o            extended immediate
//   imm_s_o          1 selects imm_o as ALU source operand
//   en_o             register-file write enable pulse
//   psr_o            last captured flags
//   illegal_o        pulse on an undecodable instruction
//   instr_count_o    count of retired legal instructions
module instr_decode_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [4:0]  flags_i,
  output logic [3:0]  rdest_reg_loc_o,
  output logic [3:0]  rsrc_reg_loc_o,
  output logic [4:0]  op_code_o,
  output logic [15:0] imm_o,
  output logic        imm_s_o,
  output logic        en_o,
  output logic [4:0]  psr_o,
  output logic        illegal_o,
  output logic [15:0] instr_count_o
);

  localparam logic [4:0] OpAdd = 5'd0;
  localparam logic [4:0] OpSub = 5'd1;
  localparam logic [4:0] OpCmp = 5'd2;
  localparam logic [4:0] OpAnd = 5'd3;
  localparam logic [4:0] OpOr  = 5'd4;
  localparam logic [4:0] OpXor = 5'd5;

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e      state_q;
  logic        instr_ready_q;
  logic [3:0]  rdest_q;
  logic [3:0]  rsrc_q;
  logic [4:0]  op_q;
  logic [15:0] imm_q;
  logic        imm_s_q;
  logic        en_q;
  logic [4:0]  psr_q;
  logic        illegal_q;
  logic        is_illegal_q;
  logic [15:0] count_q;

  // Combinational decode of the presented word; latched only on handshake.
  logic [3:0]  dec_rdest;
  logic [3:0]  dec_rsrc;
  logic [4:0]  dec_op;
  logic [15:0] dec_imm;
  logic        dec_imm_s;
  logic        dec_illegal;
  logic [15:0] imm_sext;
  logic [15:0] imm_zext;

  assign imm_sext = {{8{instr_i[7]}}, instr_i[7:0]};
  assign imm_zext = {8'h00, instr_i[7:0]};

  always_comb begin
    dec_rdest   = instr_i[11:8];
    dec_rsrc    = 4'h0;
    dec_op      = OpAdd;
    dec_imm     = 16'h0000;
    dec_imm_s   = 1'b0;
    dec_illegal = 1'b0;
    case (instr_i[15:12])
      4'b0000: begin
        // R-type: ext selects the ALU op directly; only 0..9 exist.
        if (instr_i[7:4] <= 4'd9) begin
          dec_op   = {1'b0, instr_i[7:4]};
          dec_rsrc = instr_i[3:0];
        end else begin
          dec_illegal = 1'b1;
        end
      end
      4'b0101: begin dec_op = OpAdd; dec_imm = imm_sext; dec_imm_s = 1'b1; end
      4'b1001: begin dec_op = OpSub; dec_imm = imm_sext; dec_imm_s = 1'b1; end
      4'b1011: begin dec_op = OpCmp; dec_imm = imm_sext; dec_imm_s = 1'b1; end
      4'b0001: begin dec_op = OpAnd; dec_imm = imm_zext; dec_imm_s = 1'b1; end
      4'b0010: begin dec_op = OpOr;  dec_imm = imm_zext; dec_imm_s = 1'b1; end
      4'b0011: begin dec_op = OpXor; dec_imm = imm_zext; dec_imm_s = 1'b1; end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      instr_ready_q <= 1'b0;
      rdest_q       <= 4'h0;
      rsrc_q        <= 4'h0;
      op_q          <= 5'd0;
      imm_q         <= 16'h0000;
      imm_s_q       <= 1'b0;
      en_q          <= 1'b0;
      psr_q         <= 5'd0;
      illegal_q     <= 1'b0;
      is_illegal_q  <= 1'b0;
      count_q       <= 16'h0000;
    end else begin
      en_q      <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (instr_ready_q && instr_valid_i) begin
            rdest_q       <= dec_rdest;
            rsrc_q        <= dec_rsrc;
            op_q          <= dec_op;
            imm_q         <= dec_imm;
            imm_s_q       <= dec_imm_s;
            is_illegal_q  <= dec_illegal;
            illegal_q     <= dec_illegal;
            instr_ready_q <= 1'b0;
            state_q       <= StExec;
          end else begin
            // Ready only rises one edge after reset release, so no transfer on that edge.
            instr_ready_q <= 1'b1;
          end
        end
        StExec: begin
          if (is_illegal_q) begin
            instr_ready_q <= 1'b1;
            state_q       <= StIdle;
          end else begin
            // Compare only updates flags; it never writes the register file.
            en_q    <= (op_q != OpCmp);
            state_q <= StWb;
          end
        end
        StWb: begin
          psr_q         <= flags_i;
          count_q       <= count_q + 16'd1;
          instr_ready_q <= 1'b1;
          state_q       <= StIdle;
        end
        default: begin
          instr_ready_q <= 1'b0;
          state_q       <= StIdle;
        end
      endcase
    end
  end

  assign instr_ready_o   = instr_ready_q;
  assign rdest_reg_loc_o = rdest_q;
  assign rsrc_reg_loc_o  = rsrc_q;
  assign op_code_o       = op_q;
  assign imm_o           = imm_q;
  assign imm_s_o         = imm_s_q;
  assign en_o            = en_q;
  assign psr_o           = psr_q;
  assign illegal_o       = illegal_q;
  assign instr_count_o   = count_q;

endmodule
